// File: rtl/borrow_lookahead_sub_seq.sv
// borrow_lookahead_sub_seq
//   Multi-cycle unsigned subtractor: D = A - B - Bin over WIDTH bits.
//   One 4-bit slice is processed per clock, LSB slice first. Inside each slice
//   the borrow chain is flattened into borrow-lookahead terms, which mirrors
//   the 4-bit carry-lookahead adder but for the subtract direction.
//
//   Optional feature macro: SUB_OVF_FLAG_EN. When it is defined, the OVF port
//   and the signed-overflow logic are included.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operands valid
//   in_ready   out  1      operands can be accepted (IDLE only)
//   A          in   WIDTH  minuend
//   B          in   WIDTH  subtrahend
//   Bin        in   1      borrow-in
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer takes the result
//   D          out  WIDTH  difference, modulo 2^WIDTH
//   BO         out  1      borrow-out, 1 iff A < B + Bin
//   OVF        out  1      signed overflow (SUB_OVF_FLAG_EN only)
//   dbg_state  out  2      current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// and D/BO/OVF stay stable until out_ready is seen. Operands are sampled only
// at the accept edge.

module borrow_lookahead_sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BO,
`ifdef SUB_OVF_FLAG_EN
  output logic             OVF,
`endif
  output logic [1:0]       dbg_state
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             bi;
  logic [CW-1:0]    cnt;

  // Current slice operands and lookahead terms.
  logic [3:0] sa;
  logic [3:0] sb;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] bc;
  logic [3:0] sd;

  assign dbg_state = state;

  always_comb begin
    sa = a_reg[{cnt, 2'b00} +: 4];
    sb = b_reg[{cnt, 2'b00} +: 4];
    // Generate: this bit borrows by itself (a=0, b=1).
    // Propagate: an incoming borrow passes through (a == b).
    g  = ~sa & sb;
    p  = ~(sa ^ sb);
    bc[0] = bi;
    bc[1] = g[0] | (p[0] & bi);
    bc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    bc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & bi);
    bc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);
    sd = sa ^ sb ^ bc[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      bi        <= 1'b0;
      cnt       <= '0;
      D         <= '0;
      BO        <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      OVF       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            bi       <= Bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // D is overwritten slice by slice; upper slices keep the previous
          // result until their turn comes.
          D[{cnt, 2'b00} +: 4] <= sd;
          bi <= bc[4];
          if (cnt == CW'(NSLICE - 1)) begin
            BO        <= bc[4];
`ifdef SUB_OVF_FLAG_EN
            // Signed overflow: borrow into the MSB differs from borrow out.
            OVF       <= bc[3] ^ bc[4];
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_borrow_lookahead_sub_seq.sv
// Bench for borrow_lookahead_sub_seq (WIDTH=16): directed corner cases,
// output back-pressure, reset mid-operation and randomized operands, with a
// queue-based scoreboard fed at each accept and drained by a monitor.

module tb_borrow_lookahead_sub_seq;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] D;
  logic         BO;
`ifdef SUB_OVF_FLAG_EN
  logic         OVF;
`endif
  logic [1:0]   dbg_state;

  int passed = 0;
  int total  = 0;

  // Expected entry: {ovf, bo, d}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;

  borrow_lookahead_sub_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .BO        (BO),
`ifdef SUB_OVF_FLAG_EN
    .OVF       (OVF),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic on the whole operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic bin);
    longint ud, sd;
    logic   bo, ovf;
    logic [W-1:0] d;
    ud  = longint'(a) - longint'(b) - longint'(bin);
    sd  = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    bo  = (ud < 0);
    d   = ud[W-1:0];
    ovf = (sd > ((longint'(1) << (W - 1)) - 1)) || (sd < -(longint'(1) << (W - 1)));
    return {ovf, bo, d};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got D=%0h with no expected result", D);
      end else begin
        mon_e = exp_q.pop_front();
        check("D", int'(D), int'(mon_e[W-1:0]));
        check("BO", int'(BO), int'(mon_e[W]));
`ifdef SUB_OVF_FLAG_EN
        check("OVF", int'(OVF), int'(mon_e[W+1]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin);
    wait_ready();
    in_valid = 1'b1;
    A = a;
    B = b;
    Bin = bin;
    @(posedge clk);
    exp_q.push_back(model(a, b, bin));
    #1;
    // Scramble operands after the accept edge; they must not matter.
    in_valid = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    Bin = 1'($urandom_range(0, 1));
  endtask

  task automatic check_latency();
    repeat (NS - 1) @(posedge clk);
    #1 check("lat_early", int'(out_valid), 0);
    @(posedge clk);
    #1 check("lat", int'(out_valid), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((out_valid || !in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", int'(in_ready && !out_valid), 1);
  endtask

  // ---------------- main sequence ----------------
  logic [W+1:0] hold_e;
  logic [W-1:0] ra, rb;
  logic         rbin;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_D", int'(D), 0);
    check("rst_BO", int'(BO), 0);
    check("rst_state", int'(dbg_state), 0);
`ifdef SUB_OVF_FLAG_EN
    check("rst_OVF", int'(OVF), 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases
    out_ready = 1'b1;
    issue(16'h1234, 16'h0234, 1'b0); check_latency(); wait_idle();
    issue(16'h0000, 16'h0001, 1'b0); check_latency(); wait_idle();
    issue(16'h8000, 16'h0001, 1'b0); check_latency(); wait_idle();
    issue(16'h0000, 16'h0000, 1'b1); check_latency(); wait_idle();

    // Back-pressure in DONE with a stray operand pulse
    out_ready = 1'b0;
    issue(16'h5A5A, 16'h1234, 1'b1);
    hold_e = model(16'h5A5A, 16'h1234, 1'b1);
    check_latency();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_D", int'(D), int'(hold_e[W-1:0]));
      check("hold_BO", int'(BO), int'(hold_e[W]));
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_valid", int'(out_valid), 1);
      in_valid = (k == 1);
      A = 16'hFFFF;
      B = 16'h0001;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", int'(out_valid), 0);
    check("release_in_ready", int'(in_ready), 1);
    check("release_q", exp_q.size(), 0);
    @(posedge clk); #1;
    check("release_state", int'(dbg_state), 0);

    // Reset in the second RUN cycle
    out_ready = 1'b1;
    issue(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_D", int'(D), 0);
    check("abort_in_ready", int'(in_ready), 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(16'hFFFF, 16'hFFFF, 1'b0); check_latency(); wait_idle();

    // Randomized operands with random output stalls
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       begin ra = '0;          rb = W'($urandom); end
        1:       begin ra = W'($urandom); rb = '1;          end
        default: begin ra = W'($urandom); rb = W'($urandom); end
      endcase
      rbin = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      issue(ra, rb, rbin);
      check_latency();
      if (!out_ready) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      wait_idle();
    end

    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
